// File: rtl/score_text_renderer.sv
// HUD text source: draws "SCORE:dddd" from an 8x16 glyph ROM, converting the
// per-frame score capture to BCD with an iterative double-dabble FSM.
module score_text_renderer #(
    parameter logic [9:0] TEXT_X  = 10'd8,
    parameter logic [9:0] TEXT_Y  = 10'd8,
    parameter int         SCORE_W = 14
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic [SCORE_W-1:0] score,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [7:0]         font_addr,
    input  logic [7:0]         font_data,
    output logic               text_on,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(9999);
    localparam logic [3:0]         CNT_LAST  = 4'(SCORE_W - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [SCORE_W-1:0]   sat_q, sat_d;
    logic [15:0]          acc_q, acc_d;
    logic [15:0]          digits_q, digits_d;
    logic                 busy_q, busy_d;
    logic                 text_on_q, text_on_d;

    logic [15:0]          acc_adj;
    logic [6:0]           dx;
    logic [3:0]           dy;
    logic [3:0]           char_idx;
    logic [2:0]           col;
    logic [3:0]           glyph;
    logic                 in_region;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sat_q     <= '0;
            acc_q     <= '0;
            digits_q  <= '0;
            busy_q    <= 1'b0;
            text_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            acc_q     <= acc_d;
            digits_q  <= digits_d;
            busy_q    <= busy_d;
            text_on_q <= text_on_d;
        end
    end

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        acc_d    = acc_q;
        digits_d = digits_q;
        busy_d   = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    sat_d   = (score > SCORE_MAX) ? SCORE_MAX : score;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                acc_d = 16'({acc_adj, sat_q[SCORE_W-1]});
                sat_d = {sat_q[SCORE_W-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d = acc_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Raster address path; bits beyond the string width are irrelevant inside the region.
    always_comb begin
        in_region = (DrawX >= TEXT_X) && (DrawX < TEXT_X + 10'd80) &&
                    (DrawY >= TEXT_Y) && (DrawY < TEXT_Y + 10'd16);
        dx        = 7'(DrawX - TEXT_X);
        dy        = 4'(DrawY - TEXT_Y);
        char_idx  = dx[6:3];
        col       = dx[2:0];
        unique case (char_idx)
            4'd0:    glyph = 4'd11;
            4'd1:    glyph = 4'd12;
            4'd2:    glyph = 4'd13;
            4'd3:    glyph = 4'd14;
            4'd4:    glyph = 4'd15;
            4'd5:    glyph = 4'd10;
            4'd6:    glyph = digits_q[15:12];
            4'd7:    glyph = digits_q[11:8];
            4'd8:    glyph = digits_q[7:4];
            4'd9:    glyph = digits_q[3:0];
            default: glyph = 4'd0;
        endcase
        font_addr = in_region ? {glyph, dy} : 8'h00;
        text_on_d = in_region & font_data[3'd7 - col];
    end

    assign text_on = text_on_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_score_text_renderer.sv
// Directed bench for score_text_renderer: a ROM model feeds font_data and a
// queue scoreboard holds the expected registered text_on for each pixel driven.
module tb_score_text_renderer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic [13:0] score;
    logic [9:0]  DrawX, DrawY;
    logic [7:0]  font_addr, font_data;
    logic        text_on, busy;

    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_d[4];
    logic exp_q[$];

    always #5 Clk = ~Clk;

    score_text_renderer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .score      (score),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .text_on    (text_on),
        .busy       (busy)
    );

    // Arbitrary but fixed glyph ROM; S row 2 is pinned to its real pattern.
    function automatic logic [7:0] rom_model(input logic [7:0] a);
        return (a == 8'hB2) ? 8'h7C : (a ^ 8'h96);
    endfunction

    assign font_data = rom_model(font_addr);

    function automatic logic [7:0] addr_model(input int x, input int y);
        int ch;
        int g;
        if (x < 8 || x >= 88 || y < 8 || y >= 24) return 8'h00;
        ch = (x - 8) / 8;
        if (ch < 5)       g = 11 + ch;
        else if (ch == 5) g = 10;
        else              g = exp_d[ch - 6];
        return 8'((g * 16) + (y - 8));
    endfunction

    function automatic logic text_model(input int x, input int y);
        logic [7:0] row_bits;
        if (x < 8 || x >= 88 || y < 8 || y >= 24) return 1'b0;
        row_bits = rom_model(addr_model(x, y));
        return row_bits[7 - ((x - 8) % 8)];
    endfunction

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int x, input int y);
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        compare("font_addr", 16'(font_addr), 16'(addr_model(x, y)));
        exp_q.push_back(text_model(x, y));
    endtask

    task automatic checkOutput();
        logic e;
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            compare("scoreboard_empty", 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            compare("text_on", 16'(text_on), 16'(e));
        end
    endtask

    task automatic pixel(input int x, input int y);
        applyStimulus(x, y);
        checkOutput();
    endtask

    task automatic checkDigits();
        for (int i = 0; i < 4; i++) pixel(8 + 48 + 8 * i, 8 + 2);
    endtask

    task automatic setExpected(input int sc);
        int s;
        s = (sc > 9999) ? 9999 : sc;
        exp_d[0] = s / 1000;
        exp_d[1] = (s / 100) % 10;
        exp_d[2] = (s / 10) % 10;
        exp_d[3] = s % 10;
    endtask

    // Pulse frame_start, scramble score after capture, count busy cycles (bounded).
    task automatic runConvert(input int sc);
        int n;
        @(negedge Clk);
        score       = 14'(sc);
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        frame_start = 1'b0;
        score       = 14'($urandom);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk);
            #1;
            if (busy) n++;
            else if (n > 0) break;
        end
        compare("busy_cycles", 16'(n), 16'd15);
        setExpected(sc);
    endtask

    initial begin
        int fall;
        Reset       = 1'b1;
        frame_start = 1'b0;
        score       = '0;
        DrawX       = '0;
        DrawY       = '0;
        exp_d       = '{0, 0, 0, 0};
        $display("[TB] reset");
        repeat (2) @(posedge Clk);
        #1;
        compare("reset_text_on", 16'(text_on), 16'd0);
        compare("reset_busy", 16'(busy), 16'd0);
        @(negedge Clk);
        Reset = 1'b0;
        pixel(8 + 49, 8 + 2);

        $display("[TB] convert 1234");
        runConvert(1234);
        checkDigits();
        pixel(8 + 48, 8 + 2);
        pixel(8, 8 + 2);
        pixel(8 + 1, 8 + 2);
        for (int x = 8; x < 88; x += 7) pixel(x, 8 + 5);

        $display("[TB] saturation");
        runConvert(12000);
        checkDigits();
        pixel(8 + 72, 8 + 6);

        $display("[TB] frame_start while busy");
        @(negedge Clk);
        score       = 14'd5;
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        frame_start = 1'b0;
        fall = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clk);
            #1;
            if (k > 1 && !busy) begin
                fall = k;
                break;
            end
            if (k == 4) begin
                @(negedge Clk);
                score       = 14'd7;
                frame_start = 1'b1;
            end else if (k == 5) begin
                @(negedge Clk);
                frame_start = 1'b0;
            end
        end
        compare("busy_fall_edge", 16'(fall), 16'd16);
        setExpected(5);
        checkDigits();

        $display("[TB] reset mid-convert");
        @(negedge Clk);
        score       = 14'd1234;
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        frame_start = 1'b0;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        compare("reset_mid_busy", 16'(busy), 16'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        compare("post_reset_busy", 16'(busy), 16'd0);
        setExpected(0);
        checkDigits();

        $display("[TB] region boundaries");
        pixel(8 + 80, 8 + 2);
        pixel(8 + 50, 8 + 16);
        pixel(7, 8 + 2);
        pixel(8 + 79, 8 + 15);
        pixel(8 + 40, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
